carry_chain_serial: RTL



---
 rtl/carry_chain_serial.sv | 117 +++++++++++
 1 files changed

// File: rtl/carry_chain_serial.sv
// Bit-serial carry resolution: captures p = a ^ b, g = a & b, then resolves one carry per clock.
// Optional CARRY_EARLY_TERM_EN: finish as soon as no upper propagate bit remains.
module carry_chain_serial #(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             busy
);

    // state  | meaning
    // IDLE   | waiting for operands, in_ready high
    // RIPPLE | resolving carry[idx+1] each clock
    // DONE   | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RIPPLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  g;
    logic [IDXW-1:0]   idx;
    logic              carry_next;
    logic              early_term;
    logic [WIDTH-1:0]  c_fill;

    // Mask-select bit idx of the generate/propagate term so no partial-vector temporaries are needed.
    assign carry_next = |((g | (p & c)) & (WIDTH'(1) << idx));

`ifdef CARRY_EARLY_TERM_EN
    assign early_term = ((p >> idx) == '0);
`else
    assign early_term = 1'b0;
`endif

    // With no propagate bit at or above idx, every remaining carry is just the local generate.
    always_comb begin
        c_fill    = c;
        c_fill[0] = c[0];
        for (int k = 0; k < WIDTH - 1; k++) begin
            c_fill[k+1] = (IDXW'(k) >= idx) ? g[k] : c[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            p         <= '0;
            g         <= '0;
            c         <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        p        <= a ^ b;
                        g        <= a & b;
                        c        <= {{(WIDTH-1){1'b0}}, cin};
                        idx      <= '0;
                        state    <= RIPPLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RIPPLE: begin
                    if (early_term) begin
                        c         <= c_fill;
                        cout      <= g[WIDTH-1];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (idx == LAST_IDX) begin
                        cout      <= carry_next;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        c   <= c | (WIDTH'(carry_next) << (idx + 1'b1));
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule
